// File: rtl/pie_decoder.sv
// Forward-link PIE decoder: times the synchronised envelope, validates delimiter,
// data-0 and RTcal, then slices each data symbol against RTcal/2.
module pie_decoder #(
  parameter int CNT_W     = 8,
  parameter int DELIM_MIN = 20,
  parameter int DELIM_MAX = 30,
  parameter int CAL_TMO   = 96
) (
  input  logic             clk_1_92m,
  input  logic             rst,
  input  logic             dec_en,
  input  logic             demod_in,
  output logic             bit_valid,
  output logic             bit_data,
  output logic             frame_start,
  output logic             frame_end,
  output logic             dec_err,
  output logic [CNT_W-1:0] rtcal,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DMIN = CNT_W'(DELIM_MIN);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DELIM_MAX);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(CAL_TMO);

  typedef enum logic [2:0] {IDLE, DELIM, TC0, CAL, DATA} state_t;

  state_t           state, state_n;
  logic             sync1, sync2, line_d;
  logic             rise, fall;
  logic [CNT_W-1:0] low_cnt, hi_cnt, ivl, tc, pivot;
  logic             bit_valid_n, bit_data_n, frame_start_n, frame_end_n, dec_err_n;
  logic             cap_tc, cap_cal;
  logic             low_abort, hi_tmo;
  logic [CNT_W+1:0] n_w, tc2, tc4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign rise = sync2 & ~line_d;
  assign fall = ~sync2 & line_d;
  assign busy = (state == TC0) || (state == CAL) || (state == DATA);

  assign low_abort = low_cnt > DMAX;
  assign hi_tmo    = sync2 && (hi_cnt >= TMO);
  assign n_w = {2'b00, ivl};
  assign tc2 = {1'b0, tc, 1'b0};
  assign tc4 = {tc, 2'b00};

  // Sync flops idle high so reset never looks like a falling edge.
  always_ff @(posedge clk_1_92m or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync1  <= demod_in;
      sync2  <= sync1;
      line_d <= sync2;
    end
  end

  always_ff @(posedge clk_1_92m or posedge rst) begin
    if (rst) begin
      low_cnt <= '0;
      hi_cnt  <= '0;
      ivl     <= '0;
    end else begin
      if (fall)        low_cnt <= CNT_W'(1);
      else if (!sync2) low_cnt <= sat_inc(low_cnt);
      if (rise)        hi_cnt <= CNT_W'(1);
      else if (fall)   hi_cnt <= '0;
      else if (sync2)  hi_cnt <= sat_inc(hi_cnt);
      if (rise)        ivl <= CNT_W'(1);
      else             ivl <= sat_inc(ivl);
    end
  end

  always_comb begin
    state_n       = state;
    bit_valid_n   = 1'b0;
    bit_data_n    = bit_data;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    dec_err_n     = 1'b0;
    cap_tc        = 1'b0;
    cap_cal       = 1'b0;
    case (state)
      IDLE:  if (fall) state_n = DELIM;
      DELIM: if (rise) state_n = (low_cnt >= DMIN && low_cnt <= DMAX) ? TC0 : IDLE;
      TC0: begin
        if (low_abort || hi_tmo) begin
          dec_err_n = 1'b1;
          state_n   = IDLE;
        end else if (rise) begin
          cap_tc  = 1'b1;
          state_n = CAL;
        end
      end
      CAL: begin
        if (low_abort || hi_tmo) begin
          dec_err_n = 1'b1;
          state_n   = IDLE;
        end else if (rise) begin
          if (n_w > tc2 && n_w < tc4) begin
            cap_cal       = 1'b1;
            frame_start_n = 1'b1;
            state_n       = DATA;
          end else begin
            dec_err_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      DATA: begin
        // Abort and end-of-frame take precedence over a coincident rise.
        if (low_abort) begin
          dec_err_n = 1'b1;
          state_n   = IDLE;
        end else if (sync2 && ivl > rtcal) begin
          frame_end_n = 1'b1;
          state_n     = IDLE;
        end else if (rise) begin
          bit_valid_n = 1'b1;
          bit_data_n  = ivl >= pivot;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!dec_en) begin
      state_n       = IDLE;
      bit_valid_n   = 1'b0;
      bit_data_n    = bit_data;
      frame_start_n = 1'b0;
      frame_end_n   = 1'b0;
      dec_err_n     = 1'b0;
      cap_tc        = 1'b0;
      cap_cal       = 1'b0;
    end
  end

  always_ff @(posedge clk_1_92m or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_valid   <= 1'b0;
      bit_data    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      dec_err     <= 1'b0;
      rtcal       <= '0;
      tc          <= '0;
      pivot       <= '0;
    end else begin
      state       <= state_n;
      bit_valid   <= bit_valid_n;
      bit_data    <= bit_data_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
      dec_err     <= dec_err_n;
      if (cap_tc) tc <= ivl;
      if (cap_cal) begin
        rtcal <= ivl;
        pivot <= ivl >> 1;
      end
    end
  end

endmodule

// File: tb/tb_pie_decoder.sv
// Randomised frame bench: an event-level PIE model predicts strobe timing/values
// from symbol durations; a monitor logs what the decoder actually emits.
module tb_pie_decoder;
  localparam int CNT_W = 8;
  localparam int K_START = 1, K_BIT = 2, K_END = 3, K_ERR = 4;

  logic             clk_1_92m = 1'b0;
  logic             rst = 1'b1;
  logic             dec_en = 1'b1;
  logic             demod_in = 1'b1;
  logic             bit_valid, bit_data, frame_start, frame_end, dec_err, busy;
  logic [CNT_W-1:0] rtcal;

  pie_decoder #(.CNT_W(CNT_W)) dut (
    .clk_1_92m(clk_1_92m), .rst(rst), .dec_en(dec_en), .demod_in(demod_in),
    .bit_valid(bit_valid), .bit_data(bit_data), .frame_start(frame_start),
    .frame_end(frame_end), .dec_err(dec_err), .rtcal(rtcal), .busy(busy)
  );

  always #5 clk_1_92m = ~clk_1_92m;

  int cyc = 0;
  always @(posedge clk_1_92m) cyc++;

  int     n_chk = 0, n_fail = 0;
  longint exp_q[$], act_q[$];
  int     sh[1:16], sl[1:16];
  int     exp_rt = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event code: cycle*16 + kind*2 + data
  function automatic longint ev(input int t, input int k, input int d);
    return longint'(t) * 16 + longint'(k * 2 + d);
  endfunction

  always @(negedge clk_1_92m) begin
    if (frame_start | bit_valid | frame_end | dec_err) begin
      chk("onehot", $countones({frame_start, bit_valid, frame_end, dec_err}), 1);
      if (frame_start)    act_q.push_back(ev(cyc, K_START, 0));
      else if (bit_valid) act_q.push_back(ev(cyc, K_BIT, int'(bit_data)));
      else if (frame_end) act_q.push_back(ev(cyc, K_END, 0));
      else                act_q.push_back(ev(cyc, K_ERR, 0));
    end
  end

  // One level held for dur clocks; t = index of the first posedge sampling it.
  task automatic drive(input bit lvl, input int dur, output int t);
    @(negedge clk_1_92m);
    t = cyc + 1;
    demod_in = lvl;
    repeat (dur - 1) @(negedge clk_1_92m);
  endtask

  task automatic idle(input int n);
    int t;
    drive(1'b1, n, t);
  endtask

  // Drive delimiter + symbols (high then low each) and predict the strobes.
  // A synced rise reaches the outputs 2 posedges after its first sampling edge.
  task automatic run_frame(input int d, input int ns, input bit want_end);
    int t, tc, rt, n;
    int r[0:16];
    drive(1'b0, d, t);
    r[0] = t + d;
    for (int k = 1; k <= ns; k++) begin
      drive(1'b1, sh[k], t);
      drive(1'b0, sl[k], t);
      r[k] = r[k-1] + sh[k] + sl[k];
    end
    if (d < 20 || d > 30) return;
    tc = 0;
    rt = 0;
    for (int k = 1; k <= ns; k++) begin
      if (k <= 2 && sh[k] >= 96) begin
        exp_q.push_back(ev(r[k-1] + 98, K_ERR, 0));
        return;
      end
      if (sl[k] >= 31) begin
        exp_q.push_back(ev(r[k-1] + sh[k] + 33, K_ERR, 0));
        return;
      end
      n = sh[k] + sl[k];
      if (k == 1) tc = n;
      else if (k == 2) begin
        if (n > 2 * tc && n < 4 * tc) begin
          rt = n;
          exp_rt = n;
          exp_q.push_back(ev(r[2] + 2, K_START, 0));
        end else begin
          exp_q.push_back(ev(r[2] + 2, K_ERR, 0));
          return;
        end
      end else exp_q.push_back(ev(r[k] + 2, K_BIT, (n >= rt / 2) ? 1 : 0));
    end
    if (ns >= 2 && want_end) exp_q.push_back(ev(r[ns] + 3 + rt, K_END, 0));
  endtask

  task automatic settle(input string tag);
    chk({tag, "_nev"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({tag, "_ev"}, act_q[i], exp_q[i]);
    chk({tag, "_busy"}, busy, 0);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic set_sym(input int k, input int hi, input int lo);
    sh[k] = hi;
    sl[k] = lo;
  endtask

  task automatic load_t1();
    set_sym(1, 9, 3);  set_sym(2, 30, 3); set_sym(3, 9, 3);
    set_sym(4, 18, 3); set_sym(5, 18, 3); set_sym(6, 9, 3);
  endtask

  task automatic interrupt(input bit use_rst);
    int t;
    load_t1();
    run_frame(24, 4, 1'b0);
    drive(1'b1, 5, t);
    @(negedge clk_1_92m);
    if (use_rst) begin
      rst = 1'b1;
      exp_rt = 0;
    end else dec_en = 1'b0;
    @(negedge clk_1_92m);
    chk("intr_strobes", {bit_valid, frame_start, frame_end, dec_err}, 0);
    chk("intr_busy", busy, 0);
    chk("intr_rtcal", rtcal, exp_rt);
    rst = 1'b0;
    dec_en = 1'b1;
    idle(60);
    settle("intr");
  endtask

  initial begin
    int tc, rt, pw, nd, mode, d;
    repeat (3) @(negedge clk_1_92m);
    chk("rst_out", {bit_valid, bit_data, frame_start, frame_end, dec_err, busy}, 0);
    chk("rst_rtcal", rtcal, 0);
    rst = 1'b0;
    idle(10);

    load_t1();
    run_frame(24, 6, 1'b1);
    idle(60);
    settle("t1");
    chk("t1_rtcal", rtcal, 33);

    load_t1();
    run_frame(15, 6, 1'b1);
    idle(60);
    settle("t2_short_delim");

    set_sym(1, 9, 3); set_sym(2, 17, 3);
    run_frame(24, 2, 1'b1);
    idle(60);
    settle("t3_bad_cal");
    chk("t3_rtcal_hold", rtcal, 33);

    set_sym(1, 9, 3); set_sym(2, 30, 3); set_sym(3, 9, 3); set_sym(4, 9, 40);
    run_frame(24, 4, 1'b1);
    idle(60);
    settle("t4_long_low");

    set_sym(1, 9, 3); set_sym(2, 30, 3); set_sym(3, 13, 3); set_sym(4, 12, 3);
    run_frame(24, 4, 1'b1);
    idle(60);
    settle("t5_pivot");

    interrupt(1'b1);
    interrupt(1'b0);
    load_t1();
    run_frame(24, 6, 1'b1);
    idle(60);
    settle("t6_fresh");
    chk("t6_rtcal", rtcal, 33);

    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 6);
      tc = $urandom_range(8, 20);
      pw = $urandom_range(2, 6);
      set_sym(1, tc - pw, pw);
      rt = $urandom_range(2 * tc + 1, 4 * tc - 1);
      if (mode == 4)
        rt = $urandom_range(0, 1) ? $urandom_range(8, 2 * tc) : $urandom_range(4 * tc, 4 * tc + 10);
      pw = $urandom_range(2, 6);
      set_sym(2, rt - pw, pw);
      nd = $urandom_range(1, 8);
      for (int k = 3; k < 3 + nd; k++) begin
        pw = $urandom_range(2, 6);
        set_sym(k, $urandom_range(tc, rt) - pw, pw);
      end
      d = $urandom_range(20, 30);
      if (mode == 3) d = $urandom_range(0, 1) ? $urandom_range(4, 19) : $urandom_range(31, 60);
      if (mode == 5) sl[2 + nd] = $urandom_range(31, 60);
      if (mode == 6) begin
        set_sym(1, $urandom_range(96, 110), 4);
        nd = -1;
      end
      run_frame(d, 2 + nd, 1'b1);
      idle(110);
      settle("rnd");
      chk("rnd_rtcal", rtcal, exp_rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
